// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Holds the loader state encoding and the byte counts of the stream fields.
package loader_pkg;

   typedef enum logic [2:0] {
      LOAD_LEN  = 3'd0,
      LOAD_DATA = 3'd1,
      LOAD_SUM  = 3'd2,
      FINISH    = 3'd3,
      DONE      = 3'd4,
      ERROR     = 3'd5
   } loader_state_t;

   localparam int LEN_BYTES  = 4;
   localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Shifts stream bytes into a 32-bit little-endian word and tracks the byte index.
// Shared by the length field and the data words, which have the same size.
module byte_packer
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        shift_en,
   input  logic [7:0]  byte_in,
   output logic [31:0] word_next,
   output logic        word_complete
);

   localparam int IDX_W = $clog2(WORD_BYTES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

   logic [31:0]      word_q, word_d;
   logic [IDX_W-1:0] idx_q, idx_d;

   // New bytes enter at the top so the first byte ends up in bits [7:0].
   assign word_next     = {byte_in, word_q[31:8]};
   assign word_complete = shift_en && (idx_q == LAST_IDX);

   always_comb begin
      word_d = word_q;
      idx_d  = idx_q;
      if (clear) begin
         word_d = '0;
         idx_d  = '0;
      end else if (shift_en) begin
         word_d = word_next;
         idx_d  = idx_q + IDX_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         word_q <= '0;
         idx_q  <= '0;
      end else begin
         word_q <= word_d;
         idx_q  <= idx_d;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Run-time instruction-memory loader: length-prefixed byte stream in, word writes out.
// Optional trailing checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader
   import loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_data,
   output logic                  rx_ready,
   input  logic                  reload,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  core_hold,
   output logic                  done,
   output logic                  error
);

   localparam logic [31:0]         MAX_WORDS = 32'd1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] ONE_WORD  = (ADDR_WIDTH+1)'(1);

   loader_state_t         state_q, state_d;
   logic                  rx_ready_q, rx_ready_d;
   logic                  imem_we_q, imem_we_d;
   logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
   logic [31:0]           imem_wdata_q, imem_wdata_d;
   logic                  core_hold_q, core_hold_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;
   logic [ADDR_WIDTH:0]   len_q, len_d;
   logic [ADDR_WIDTH:0]   words_q, words_d;

   logic        accept;
   logic        pack_en;
   logic        pack_clear;
   logic        word_complete;
   logic [31:0] word_next;

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0] sum_q, sum_d;
   logic [7:0] sum_total;
   assign sum_total = sum_q + rx_data;
   localparam loader_state_t TAIL_STATE = LOAD_SUM;
`else
   localparam loader_state_t TAIL_STATE = FINISH;
`endif

   assign accept  = rx_valid && rx_ready_q;
   assign pack_en = accept && ((state_q == LOAD_LEN) || (state_q == LOAD_DATA));

   byte_packer u_packer (
      .clk           (clk),
      .reset         (reset),
      .clear         (pack_clear),
      .shift_en      (pack_en),
      .byte_in       (rx_data),
      .word_next     (word_next),
      .word_complete (word_complete)
   );

   always_comb begin
      state_d      = state_q;
      imem_we_d    = 1'b0;
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;
      len_d        = len_q;
      words_d      = words_q;
      pack_clear   = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_d        = sum_q;
`endif

      // The address advances once the pulse for the current word has been issued.
      if (imem_we_q) imem_addr_d = imem_addr_q + ADDR_WIDTH'(1);

      case (state_q)
         LOAD_LEN: begin
            if (word_complete) begin
               len_d   = word_next[ADDR_WIDTH:0];
               words_d = '0;
               if (word_next > MAX_WORDS)  state_d = ERROR;
               else if (word_next == '0)   state_d = TAIL_STATE;
               else                        state_d = LOAD_DATA;
            end
         end
         LOAD_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (accept) sum_d = sum_total;
`endif
            if (word_complete) begin
               imem_we_d    = 1'b1;
               imem_wdata_d = word_next;
               words_d      = words_q + ONE_WORD;
               if (words_d == len_q) state_d = TAIL_STATE;
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         LOAD_SUM: begin
            if (accept) state_d = (sum_total == 8'h00) ? DONE : ERROR;
         end
`endif
         FINISH: state_d = DONE;
         DONE, ERROR: begin
            if (reload) begin
               state_d     = LOAD_LEN;
               imem_addr_d = '0;
               len_d       = '0;
               words_d     = '0;
               pack_clear  = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
               sum_d       = '0;
`endif
            end
         end
         default: state_d = ERROR;
      endcase

      // Flags follow the next state so they are registered alongside it.
      rx_ready_d  = (state_d == LOAD_LEN) || (state_d == LOAD_DATA) || (state_d == LOAD_SUM);
      done_d      = (state_d == DONE);
      error_d     = (state_d == ERROR);
      core_hold_d = (state_d != DONE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= LOAD_LEN;
         rx_ready_q   <= 1'b0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
         core_hold_q  <= 1'b1;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         len_q        <= '0;
         words_q      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         rx_ready_q   <= rx_ready_d;
         imem_we_q    <= imem_we_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
         core_hold_q  <= core_hold_d;
         done_q       <= done_d;
         error_q      <= error_d;
         len_q        <= len_d;
         words_q      <= words_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_q        <= sum_d;
`endif
      end
   end

   assign rx_ready   = rx_ready_q;
   assign imem_we    = imem_we_q;
   assign imem_addr  = imem_addr_q;
   assign imem_wdata = imem_wdata_q;
   assign core_hold  = core_hold_q;
   assign done       = done_q;
   assign error      = error_q;

endmodule
